vec_reduce_accum: RTL and testbench

VEC_REDUCE_ACCUM -- requirements
Module: vec_reduce_accum

---
 rtl/vec_reduce_pkg.sv | 15 +
 rtl/word_reduce.sv | 15 +
 rtl/vec_reduce_accum.sv | 92 +++++++++
 tb/tb_vec_reduce_accum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_reduce_pkg.sv
// Shared types and helpers for the vector reduce accumulator.
// Holds the packet FSM state encoding and the count-width helper.
package vec_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int count_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/word_reduce.sv
// Per-word bit reductions: AND, OR and XOR across all bits of one word.
module word_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic             w_and,
  output logic             w_or,
  output logic             w_xor
);

  assign w_and = &word;
  assign w_or  = |word;
  assign w_xor = ^word;

endmodule

// File: rtl/vec_reduce_accum.sv
// Packet-wise bit reduction accumulator with a saturating word count.
// state | meaning
// IDLE  | no packet open, waiting for the first word
// ACCUM | packet open, folding further words into the accumulators
// HOLD  | result presented, waiting for the consumer handshake
module vec_reduce_accum
  import vec_reduce_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int MAX_LEN = 16,
  localparam int CW      = count_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  state_t          state, state_nxt;
  logic            w_and, w_or, w_xor;
  logic            acc_and, acc_or, acc_xor, overflow;
  logic [CW-1:0]   count;
  logic            in_fire;

  word_reduce #(.WIDTH(WIDTH)) u_word_reduce (
    .word  (in_data),
    .w_and (w_and),
    .w_or  (w_or),
    .w_xor (w_xor)
  );

  // Handshake qualifiers decode only registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = in_last ? HOLD : ACCUM;
      ACCUM:   if (in_fire && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      acc_and  <= 1'b0;
      acc_or   <= 1'b0;
      acc_xor  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        if (state == IDLE) begin
          acc_and  <= w_and;
          acc_or   <= w_or;
          acc_xor  <= w_xor;
          count    <= CW'(1);
          overflow <= 1'b0;
        end else begin
          acc_and <= acc_and & w_and;
          acc_or  <= acc_or | w_or;
          acc_xor <= acc_xor ^ w_xor;
          // Count pins at MAX_LEN; the word still folds into the reductions.
          if (count == CW'(MAX_LEN)) overflow <= 1'b1;
          else                       count    <= count + CW'(1);
        end
      end
    end
  end

  // Accumulators are frozen in HOLD because in_ready is low there.
  assign out_and      = acc_and;
  assign out_or       = acc_or;
  assign out_xor      = acc_xor;
  assign out_count    = count;
  assign out_overflow = overflow;

endmodule

// File: tb/tb_vec_reduce_accum.sv
// Directed bench for vec_reduce_accum with WIDTH=4, MAX_LEN=4.
module tb_vec_reduce_accum;

  localparam int WIDTH   = 4;
  localparam int MAX_LEN = 4;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             areset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_and, out_or, out_xor, out_overflow;
  logic [CW-1:0]    out_count;

  int n_total = 0;
  int n_bad   = 0;

  vec_reduce_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_and      (out_and),
    .out_or       (out_or),
    .out_xor      (out_xor),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [3:0] d, input logic last);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      @(negedge clk);
    end
    chk("send_accept", {31'b0, acc}, 32'd1);
    in_valid = 1'b0;
    in_data  = 4'hA;
    in_last  = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("gap_no_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic a, input logic o, input logic x,
                              input logic [CW-1:0] c, input logic v);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_and"},   {31'b0, out_and}, {31'b0, a});
    chk({tag, "_or"},    {31'b0, out_or}, {31'b0, o});
    chk({tag, "_xor"},   {31'b0, out_xor}, {31'b0, x});
    chk({tag, "_count"}, {{(32-CW){1'b0}}, out_count}, {{(32-CW){1'b0}}, c});
    chk({tag, "_ovf"},   {31'b0, out_overflow}, {31'b0, v});
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_pop_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_pop_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  logic [3:0] words [5] = '{4'hF, 4'h0, 4'h7, 4'h8, 4'h3};

  initial begin
    logic [CW-1:0] s_count;
    logic          s_and, s_or, s_xor, s_ovf;
    int idx, got, last_cyc;
    logic fire;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_outs", {26'b0, out_and, out_or, out_xor, out_overflow, 2'b0} | {29'b0, out_count},
        32'd0);
    areset_n = 1'b1;
    @(negedge clk);

    // Single word packet
    send_word(4'b1111, 1'b1);
    check_result("single", 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    take_result("single");

    // Three words with a two-cycle valid gap
    send_word(4'b1111, 1'b0);
    idle_cycles(2);
    send_word(4'b0001, 1'b0);
    send_word(4'b0000, 1'b1);
    check_result("gap", 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);

    // Backpressure: outputs stable for 5 cycles with garbage on the input side
    s_and = out_and; s_or = out_or; s_xor = out_xor; s_count = out_count; s_ovf = out_overflow;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i * 3 + 1);
      in_last  = i[0];
      @(negedge clk);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_stable", {27'b0, out_and, out_or, out_xor, out_overflow, 1'b0} | {29'b0, out_count},
          {27'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0} | 32'd3);
    end
    chk("hold_snap", {26'b0, s_and, s_or, s_xor, s_ovf, s_count[1:0]}, {26'b0, 4'b0110, 2'b11});
    in_valid = 1'b0;
    take_result("hold");

    // Exactly MAX_LEN words: count saturates, no overflow yet
    for (int i = 0; i < 4; i++) send_word(4'b1111, i == 3);
    check_result("full", 1'b1, 1'b1, 1'b0, 3'd4, 1'b0);
    take_result("full");

    // Six words: overflow
    for (int i = 0; i < 6; i++) send_word(4'b0110, i == 5);
    check_result("ovf", 1'b0, 1'b1, 1'b0, 3'd4, 1'b1);
    take_result("ovf");

    // Reset mid-packet discards partial state
    send_word(4'b1111, 1'b0);
    send_word(4'b1111, 1'b0);
    areset_n = 1'b0;
    #1;
    chk("mrst_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_count", {29'b0, out_count}, 32'd0);
    chk("mrst_and", {31'b0, out_and}, 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    send_word(4'b1000, 1'b1);
    check_result("mrst", 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
    take_result("mrst");

    // Back-to-back single-word packets, consumer always ready
    out_ready = 1'b1;
    idx = 0; got = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        if (got < 5) begin
          chk("b2b_and", {31'b0, out_and}, {31'b0, &words[got]});
          chk("b2b_or",  {31'b0, out_or},  {31'b0, |words[got]});
          chk("b2b_xor", {31'b0, out_xor}, {31'b0, ^words[got]});
          chk("b2b_count", {29'b0, out_count}, 32'd1);
        end
        if (last_cyc >= 0) chk("b2b_spacing", cyc - last_cyc, 32'd2);
        last_cyc = cyc;
        got++;
      end
      if (idx < 5) begin
        in_valid = 1'b1;
        in_data  = words[idx];
        in_last  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      fire = in_valid && in_ready;
      @(negedge clk);
      if (fire) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_sent", idx, 32'd5);
    chk("b2b_got", got, 32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
